// File: rtl/matrix_bus.sv
// matrix_bus: two-master / two-slave fabric for the matrix accelerator.
// M1 keeps the bus for as long as it requests it. M0 gets the bus back
// once M1 stops requesting. The owner's address is decoded into one of
// two 32-word slave windows. Read data comes back through a registered
// path: the slave is selected in the address cycle, its data is valid one
// cycle later, and that data reaches M_din on the following edge.
module matrix_bus #(
    parameter int unsigned       ADDR_W  = 8,
    parameter int unsigned       DATA_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = 8'h00,
    parameter logic [ADDR_W-1:0] S1_BASE = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              M0_req,
    input  logic              M0_wr,
    input  logic [ADDR_W-1:0] M0_address,
    input  logic [DATA_W-1:0] M0_dout,
    input  logic              M1_req,
    input  logic              M1_wr,
    input  logic [ADDR_W-1:0] M1_address,
    input  logic [DATA_W-1:0] M1_dout,
    output logic              M0_grant,
    output logic              M1_grant,
    output logic [DATA_W-1:0] M_din,
    output logic              S0_sel,
    output logic              S1_sel,
    output logic              S_wr,
    output logic [ADDR_W-1:0] S_address,
    output logic [DATA_W-1:0] S_din,
    input  logic [DATA_W-1:0] S0_dout,
    input  logic [DATA_W-1:0] S1_dout
);

    typedef enum logic {GNT0, GNT1} state_t;
    typedef enum logic [1:0] {RSEL_NONE, RSEL_S0, RSEL_S1} rsel_t;

    state_t state, state_next;
    rsel_t  rsel, rsel_next;

    logic              req_o;
    logic              wr_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;

    // The comparison is done one bit wider than the address, so a window
    // that ends at the top of the address space does not wrap around.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base);
        logic [ADDR_W:0] a, lo, hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (ADDR_W+1)'(31);
        return (a >= lo) && (a <= hi);
    endfunction

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= GNT0;
        else          state <= state_next;
    end

    // Arbiter next state: M1 holds the bus while it requests it. M0 has priority while it owns the bus.
    always_comb begin
        state_next = state;
        unique case (state)
            GNT0: if (!M0_req && M1_req) state_next = GNT1;
            GNT1: if (!M1_req)           state_next = GNT0;
            default:                     state_next = GNT0;
        endcase
    end

    // Moore grant outputs
    always_comb begin
        M0_grant = (state == GNT0);
        M1_grant = (state == GNT1);
    end

    // Owner mux, address decode and slave-side drive
    always_comb begin
        req_o  = (state == GNT1) ? M1_req     : M0_req;
        wr_o   = (state == GNT1) ? M1_wr      : M0_wr;
        addr_o = (state == GNT1) ? M1_address : M0_address;
        data_o = (state == GNT1) ? M1_dout    : M0_dout;

        S0_sel    = req_o && in_window(addr_o, S0_BASE);
        S1_sel    = req_o && in_window(addr_o, S1_BASE);
        S_wr      = wr_o && req_o && (S0_sel || S1_sel);
        S_address = addr_o;
        S_din     = data_o;

        rsel_next = RSEL_NONE;
        if (S0_sel && !wr_o)      rsel_next = RSEL_S0;
        else if (S1_sel && !wr_o) rsel_next = RSEL_S1;
    end

    // Read path: rsel records which slave was read. On the next edge, that slave's data is loaded into M_din.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsel  <= RSEL_NONE;
            M_din <= '0;
        end else begin
            rsel <= rsel_next;
            unique case (rsel)
                RSEL_S0: M_din <= S0_dout;
                RSEL_S1: M_din <= S1_dout;
                default: M_din <= '0;
            endcase
        end
    end

endmodule
